// File: rtl/ram_access_ctrl.sv
// Access controller and data/fetch arbiter for the combinational byte-addressed RAM.
// Define RAM_ACCESS_CTRL_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module ram_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_mas,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_mas,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_done,
  output logic              busy
);

  localparam int MAX_CNT = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                own_d_q, own_d_d;
  logic                rw_q, rw_d;
  logic [1:0]          mas_q, mas_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                grant_d;

`ifdef RAM_ACCESS_CTRL_RR_EN
  // 1 = data port received the most recent grant
  logic last_d_q, last_d_d;

  assign grant_d = d_req && (!if_req || !last_d_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      rw_q       <= 1'b1;
      mas_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef RAM_ACCESS_CTRL_RR_EN
      last_d_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      own_d_q    <= own_d_d;
      rw_q       <= rw_d;
      mas_q      <= mas_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef RAM_ACCESS_CTRL_RR_EN
      last_d_q   <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    own_d_d    = own_d_q;
    rw_d       = rw_q;
    mas_d      = mas_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef RAM_ACCESS_CTRL_RR_EN
    last_d_d   = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          own_d_d = grant_d;
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
`ifdef RAM_ACCESS_CTRL_RR_EN
          last_d_d = grant_d;
`endif
          // Illegal size never reaches the RAM; bus fields keep their last values
          if (grant_d && d_mas == 2'b11) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (grant_d) begin
            rw_d    = !d_we;
            mas_d   = d_mas;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            state_d = ACCESS;
          end else begin
            rw_d    = 1'b1;
            mas_d   = 2'b10;
            addr_d  = if_addr;
            wdata_d = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Window phase ignores ram_done until the counter expires; timeout phase accepts it any cycle
        if (!tmo_q && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ram_done) begin
          if (rw_q) begin
            if (own_d_q) d_rdata_d  = ram_rdata;
            else         if_rdata_d = ram_rdata;
          end
          state_d = RESP;
        end else if (tmo_q && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!tmo_q && TIMEOUT > 0) begin
          tmo_d = 1'b1;
          cnt_d = CNT_W'(TIMEOUT - 1);
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    ram_en    = (state_q == ACCESS);
    ram_rw    = (state_q == ACCESS) ? rw_q : 1'b1;
    ram_wdata = (state_q == ACCESS) ? wdata_q : 32'h0;
    ram_mas   = mas_q;
    ram_addr  = addr_q;
    if_ack    = (state_q == RESP) && !own_d_q;
    d_ack     = (state_q == RESP) && own_d_q;
    d_err     = (state_q == RESP) && own_d_q && err_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a big-endian byte RAM model.
module tb_ram_access_ctrl;
  localparam int W = 2;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_mas = '0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic        ram_rw;
  logic [1:0]  ram_mas;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_done;
  logic        busy;
  logic        force_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_d_rd  = '0;
  logic [31:0] exp_if_rd = '0;
  bit          tb_last_d = 1'b1;

  ram_access_ctrl #(.ADDR_W(8), .WAIT_CYCLES(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_mas(d_mas), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_mas(ram_mas), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_done(ram_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: big-endian, combinational read, write applied on each enabled write edge
  logic [7:0] mem [256];
  bit         mem_ready = 1'b0;
  logic [7:0] a1, a2, a3;
  assign a1 = ram_addr + 8'd1;
  assign a2 = ram_addr + 8'd2;
  assign a3 = ram_addr + 8'd3;
  assign ram_done = !force_low;

  always_comb begin
    ram_rdata = 32'h0;
    case (ram_mas)
      2'b00:   ram_rdata = {24'h0, mem[ram_addr]};
      2'b01:   ram_rdata = {16'h0, mem[ram_addr], mem[a1]};
      2'b10:   ram_rdata = {mem[ram_addr], mem[a1], mem[a2], mem[a3]};
      default: ram_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      foreach (mem[i]) mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else if (ram_en && !ram_rw) begin
      case (ram_mas)
        2'b00: mem[ram_addr] <= ram_wdata[7:0];
        2'b01: begin
          mem[ram_addr] <= ram_wdata[15:8];
          mem[a1]       <= ram_wdata[7:0];
        end
        2'b10: begin
          mem[ram_addr] <= ram_wdata[31:24];
          mem[a1]       <= ram_wdata[23:16];
          mem[a2]       <= ram_wdata[15:8];
          mem[a3]       <= ram_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: pops one scoreboard entry per acknowledge
  always @(negedge clk) begin
    if (rst_n && (d_ack || if_ack)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'({d_ack, if_ack}), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("ack_port", 32'(d_ack), 32'(e.is_d));
        if (d_ack) begin
          check_eq("d_err", 32'(d_err), 32'(e.err));
          check_eq("d_rdata", d_rdata, e.rd);
          $display("resp data err=%0d rdata=%h", d_err, d_rdata);
        end else begin
          check_eq("if_rdata", if_rdata, e.rd);
          $display("resp fetch rdata=%h", if_rdata);
        end
      end
    end
  end

  function automatic void expect_resp(input bit is_d, input bit we, input bit err,
                                      input logic [31:0] rd);
    exp_t e;
    if (is_d) begin
      if (!we && !err) exp_d_rd = rd;
      e = '{is_d: 1'b1, err: err, rd: exp_d_rd};
    end else begin
      exp_if_rd = rd;
      e = '{is_d: 1'b0, err: 1'b0, rd: exp_if_rd};
    end
    sb.push_back(e);
  endfunction

  task automatic do_req(input bit is_d, input bit we, input logic [1:0] mas,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int exp_lat, input int exp_en);
    int n = 0;
    int en = 0;
    bit got = 0;
    bit err;
    err = is_d && (mas == 2'b11 || force_low);
    expect_resp(is_d, we, err, rd);
    tb_last_d = is_d;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_mas = mas; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    $display("req %s we=%0d mas=%0d addr=%h wdata=%h", is_d ? "data" : "fetch", we, mas, addr, wd);
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (ram_en) begin
        en++;
        check_eq("ram_mas", 32'(ram_mas), 32'(is_d ? mas : 2'b10));
        check_eq("ram_rw", 32'(ram_rw), 32'(is_d ? !we : 1'b1));
        check_eq("ram_addr", 32'(ram_addr), 32'(addr));
      end
      if (is_d ? d_ack : if_ack) got = 1;
    end
    check_eq("ack_seen", 32'(got), 32'h1);
    check_eq("latency", 32'(n), 32'(exp_lat));
    check_eq("en_cycles", 32'(en), 32'(exp_en));
    @(posedge clk); #1;
    d_req  = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic do_pair();
    int n = 0, td = 0, tf = 0;
    bit dd, fd;
    bit exp_first_d;
`ifdef RAM_ACCESS_CTRL_RR_EN
    exp_first_d = !tb_last_d;
`else
    exp_first_d = 1'b1;
`endif
    if (exp_first_d) begin
      expect_resp(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
      expect_resp(1'b0, 1'b0, 1'b0, 32'h00123400);
    end else begin
      expect_resp(1'b0, 1'b0, 1'b0, 32'h00123400);
      expect_resp(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    end
    tb_last_d = !exp_first_d;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_mas = 2'b10; d_addr = 8'h10; d_wdata = '0;
    if_req = 1'b1; if_addr = 8'h20;
    $display("req pair data@10 fetch@20 expect_first=%s", exp_first_d ? "data" : "fetch");
    while ((td == 0 || tf == 0) && n < 64) begin
      @(negedge clk);
      n++;
      dd = d_ack;
      fd = if_ack;
      if (dd) td = n;
      if (fd) tf = n;
      @(posedge clk); #1;
      if (dd) d_req = 1'b0;
      if (fd) if_req = 1'b0;
    end
    d_req = 1'b0;
    if_req = 1'b0;
    check_eq("pair_order", 32'(td != 0 && td < tf), 32'(exp_first_d));
    check_eq("pair_first_lat", 32'(exp_first_d ? td : tf), 32'(W + 2));
    check_eq("pair_gap", 32'(exp_first_d ? tf - td : td - tf), 32'(W + 2));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ram_en", 32'(ram_en), 32'h0);
    check_eq("rst_ram_rw", 32'(ram_rw), 32'h1);
    check_eq("rst_ram_mas", 32'(ram_mas), 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    check_eq("rst_acks", 32'({if_ack, d_ack, d_err}), 32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    do_req(1'b1, 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0, W + 2, W);
    do_req(1'b1, 1'b0, 2'b10, 8'h10, 32'h0, 32'hDEADBEEF, W + 2, W);
    do_req(1'b1, 1'b1, 2'b01, 8'h21, 32'h00001234, 32'h0, W + 2, W);
    do_req(1'b1, 1'b0, 2'b00, 8'h22, 32'h0, 32'h00000034, W + 2, W);
    do_req(1'b0, 1'b0, 2'b10, 8'h20, 32'h0, 32'h00123400, W + 2, W);

    do_pair();
    do_pair();

    // Illegal size: immediate error response, RAM untouched
    do_req(1'b1, 1'b0, 2'b11, 8'h44, 32'h0, 32'h0, 2, 0);

    // RAM never completes: window plus timeout, then error
    force_low = 1'b1;
    do_req(1'b1, 1'b0, 2'b10, 8'h10, 32'h0, 32'h0, W + T + 2, W + T);
    force_low = 1'b0;

    // Reset during the second ACCESS cycle
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_mas = 2'b00; d_addr = 8'h22;
    $display("req data read@22 interrupted by reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_ram_en", 32'(ram_en), 32'h1);
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    check_eq("midrst_ram_en", 32'(ram_en), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_no_ack", 32'({d_ack, if_ack}), 32'h0);
    end
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb_last_d = 1'b1;
    exp_d_rd  = '0;
    exp_if_rd = '0;
    do_req(1'b1, 1'b0, 2'b00, 8'h22, 32'h0, 32'h00000034, W + 2, W);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Clocked access controller and two-port arbiter in front of the combinational byte-addressed RAM (enable / readWrite / MAS / done interface). It shares the RAM between the CPU instruction-fetch port and the data load/store port. For each transaction it sequences enable, direction, size and address, holds them for a programmable access window, and captures read data. Each requester gets a one-cycle acknowledge with a registered read-data result.

## Interface
- `ADDR_W`, 8: RAM byte-address width.
- `WAIT_CYCLES`, 2: cycles `ram_en` is held per access; minimum 1.
- `TIMEOUT`, 15: extra cycles to wait for `ram_done` after the window before aborting with an error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Always a word read. Held until `if_ack`.
- `if_addr` in `ADDR_W`: fetch byte address.
- `if_ack` out 1: one-cycle fetch completion pulse.
- `if_rdata` out 32: fetch result, registered.
- `d_req` in 1: data request. Held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_mas` in 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `d_addr` in `ADDR_W`: data byte address.
- `d_wdata` in 32: write data, right-aligned.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_err` out 1: valid with `d_ack`. Set for illegal MAS or timeout.
- `d_rdata` out 32: data read result, registered.
- `ram_en` out 1: RAM enable.
- `ram_rw` out 1: 1 = read, 0 = write.
- `ram_mas` out 2: RAM access size.
- `ram_addr` out `ADDR_W`: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data.
- `ram_done` in 1: RAM completion flag.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample the requests and select a grant.
  - If a request is granted, register owner, address, size, direction and write data; load the counter with `WAIT_CYCLES-1`; go to ACCESS.
  - Exception: a data request with `d_mas`=11 goes directly to RESP with error set. `ram_en` never rises for it.
- Arbitration (default): fixed priority, data port over fetch port. On a simultaneous request, data wins and fetch stays pending.
- ACCESS:
  - `ram_en`=1. `ram_rw`, `ram_mas`, `ram_addr` and `ram_wdata` are driven from the registered request and held stable.
  - Fetch accesses always use MAS=10 and `ram_rw`=1.
  - The counter decrements each cycle.
  - When the counter is 0 and `ram_done`=1: capture `ram_rdata` into the owner's rdata register (reads only) and go to RESP.
  - When the counter is 0 and `ram_done`=0: continue waiting for up to `TIMEOUT` cycles, then go to RESP with error set. The rdata register is unchanged.
- RESP:
  - `ram_en`=0.
  - The owner's ack is 1 for exactly one cycle.
  - `d_err` is valid with `d_ack`; it is 0 for fetch.
  - Next state is IDLE.
- Writes do not modify `d_rdata`.
- `if_rdata` and `d_rdata` hold their value between transactions.
- When not in ACCESS: `ram_en`=0, `ram_rw`=1, `ram_wdata`=0, `ram_addr`=last value.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - `ram_en`=0, `ram_rw`=1, `ram_mas`=00, `ram_addr`=0, `ram_wdata`=0
  - `if_ack`=0, `d_ack`=0, `d_err`=0
  - `if_rdata`=0, `d_rdata`=0
  - `busy`=0
- Latency: a request sampled at edge k gives ACCESS during cycles k+1 … k+`WAIT_CYCLES`. With `ram_done` already high, ack is visible in cycle k+1+`WAIT_CYCLES` (4 cycles at the default).
- Illegal MAS: ack/err is visible in cycle k+1.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles. IDLE lasts at least one cycle between transactions.
- Handshake:
  - The requester keeps req and its fields stable until ack.
  - The request value in the cycle after ack is treated as a new request. Back-to-back requests from a registered master are legal.
  - A req drop before ack is undefined.
- Reset mid-ACCESS: `ram_en` drops at once and no ack is issued. Multi-byte RAM writes may be partial; software must reissue.
- Address wrap: `ram_addr` passes `d_addr` through unchanged. Wrap-around of `+1`/`+2`/`+3` happens inside the RAM.

## Configuration
- `RAM_ACCESS_CTRL_RR_EN` defined: round-robin arbitration.
  - A one-bit last-grant register is reset to "data".
  - On a simultaneous request, the port not granted last wins.
  - The register updates only when a grant is issued.
- `RAM_ACCESS_CTRL_RR_EN` undefined: fixed data-over-fetch priority. A continuously requesting data port starves fetch.

## Test plan
- Reset; data word write 0xDEADBEEF at address 0x10, then data word read at 0x10. Expected: `d_ack` in cycle k+3 for each; `d_rdata`=0xDEADBEEF; `d_err`=0; `ram_mas`=10 during ACCESS.
- Halfword write 0x1234 at address 0x21, byte read at 0x22. Expected: `d_rdata`=0x00000034. Fetch word read at 0x20. Expected: `if_rdata`[23:8]=0x1234.
- `if_req` and `d_req` asserted in the same cycle, both held.
  - Default: data acks first, fetch acks `WAIT_CYCLES`+2 cycles later.
  - With `RAM_ACCESS_CTRL_RR_EN`, repeated simultaneous requests alternate grants.
- Data request with `d_mas`=11. Expected: `ram_en` stays 0; `d_ack`=1 and `d_err`=1 in cycle k+1; `d_rdata` unchanged.
- `ram_done` forced to 0. Expected: `d_ack`=1 and `d_err`=1 exactly `WAIT_CYCLES`+`TIMEOUT` cycles after entering ACCESS; `ram_en` was held that long.
- Assert `rst_n`=0 during the second ACCESS cycle. Expected: `ram_en`=0 immediately, `busy`=0, no ack; next request completes normally.
